// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM bank: counter direction and duty-bus slicing.
package pwm_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // LSB position of channel ch inside the flattened duty bus.
    function automatic int unsigned duty_lsb(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty (shadow/active) and the registered compare output.
module pwm_channel #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             upd,
    input  logic             apply,
    output logic             pwm
);

    logic [WIDTH-1:0] duty_sh;
    logic [WIDTH-1:0] duty_act;

    // Apply takes the old shadow before a coincident upd overwrites it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_sh  <= '0;
            duty_act <= '0;
            pwm      <= 1'b0;
        end else begin
            if (apply) duty_act <= duty_sh;
            if (upd)   duty_sh  <= duty_in;
            pwm <= en & (cnt < duty_act);
        end
    end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator: shared edge/center-aligned period counter feeding
// NUM_CH duty comparators, with period, mode and duties applied only at period boundaries.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int NUM_CH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    center_mode,
    input  logic [WIDTH-1:0]        period_in,
    input  logic [NUM_CH*WIDTH-1:0] duty_in,
    input  logic                    upd_req,
    output logic [NUM_CH-1:0]       pwm,
    output logic [WIDTH-1:0]        cnt,
    output logic                    period_end,
    output logic                    upd_pending
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    dir_t             dir, dir_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] period_act, period_sh;
    logic             mode_act, mode_sh;
    logic             wrap, apply;

    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir;
        if (!en) begin
            cnt_nxt = '0;
            dir_nxt = DIR_UP;
        end else if (!mode_act || period_act == '0) begin
            cnt_nxt = (cnt == period_act) ? '0 : cnt + ONE;
            dir_nxt = DIR_UP;
        end else if (dir == DIR_UP) begin
            if (cnt != period_act) begin
                cnt_nxt = cnt + ONE;
            end else if (period_act == ONE) begin
                // P=1 has no down leg: straight back to 0.
                cnt_nxt = '0;
            end else begin
                cnt_nxt = period_act - ONE;
                dir_nxt = DIR_DOWN;
            end
        end else begin
            cnt_nxt = cnt - ONE;
            dir_nxt = (cnt == ONE) ? DIR_UP : DIR_DOWN;
        end
    end

    // Idle cycles load cnt=0 too, so they count as boundaries.
    assign wrap       = (cnt_nxt == '0);
    assign apply      = upd_pending & wrap;
    assign period_end = en & wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            dir         <= DIR_UP;
            period_act  <= '1;
            period_sh   <= '1;
            mode_act    <= 1'b0;
            mode_sh     <= 1'b0;
            upd_pending <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            dir <= dir_nxt;
            if (apply) begin
                period_act <= period_sh;
                mode_act   <= mode_sh;
            end
            if (upd_req) begin
                period_sh <= period_in;
                mode_sh   <= center_mode;
            end
            upd_pending <= upd_req | (upd_pending & ~wrap);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel #(.WIDTH(WIDTH)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .cnt     (cnt),
            .duty_in (duty_in[duty_lsb(i, WIDTH) +: WIDTH]),
            .upd     (upd_req),
            .apply   (apply),
            .pwm     (pwm[i])
        );
    end

endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank (WIDTH=4, NUM_CH=2): directed scenarios plus random traffic
// compared every cycle against a period-position model of the PWM bank.
module tb_pwm_bank;

    localparam int W = 4;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst, en, center_mode, upd_req;
    logic [W-1:0]   period_in;
    logic [N*W-1:0] duty_in;
    logic [N-1:0]   pwm;
    logic [W-1:0]   cnt;
    logic           period_end, upd_pending;

    int total = 0;
    int bad   = 0;

    pwm_bank #(.WIDTH(W), .NUM_CH(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .center_mode (center_mode),
        .period_in   (period_in),
        .duty_in     (duty_in),
        .upd_req     (upd_req),
        .pwm         (pwm),
        .cnt         (cnt),
        .period_end  (period_end),
        .upd_pending (upd_pending)
    );

    always #5 clk = ~clk;

    // Model: position within the period; cnt is derived from position and mode.
    int       m_pos, m_p, m_mode, s_p, s_mode;
    int       m_duty[N];
    int       s_duty[N];
    bit       m_pend;
    logic [N-1:0] m_pwm;

    function automatic int m_len();
        return (m_mode != 0 && m_p > 0) ? 2 * m_p : m_p + 1;
    endfunction

    function automatic int m_cnt();
        return (m_mode != 0 && m_pos > m_p) ? 2 * m_p - m_pos : m_pos;
    endfunction

    function automatic void m_reset();
        m_pos = 0; m_p = 15; m_mode = 0; s_p = 15; s_mode = 0; m_pend = 0; m_pwm = '0;
        for (int i = 0; i < N; i++) begin m_duty[i] = 0; s_duty[i] = 0; end
    endfunction

    function automatic void m_edge();
        int c;
        bit bnd;
        c   = m_cnt();
        bnd = !en || (m_pos + 1 == m_len());
        for (int i = 0; i < N; i++) m_pwm[i] = en && (c < m_duty[i]);
        m_pos = bnd ? 0 : m_pos + 1;
        if (bnd && m_pend) begin
            m_p = s_p; m_mode = s_mode; m_duty = s_duty; m_pend = 0;
        end
        if (upd_req) begin
            s_p = int'(period_in); s_mode = int'(center_mode); m_pend = 1;
            for (int i = 0; i < N; i++) s_duty[i] = int'(duty_in[i*W +: W]);
        end
    endfunction

    function automatic logic [7:0] exp_vec();
        logic [W-1:0] c;
        logic pe;
        c  = W'(m_cnt());
        pe = en && (m_pos + 1 == m_len());
        return {c, m_pwm, pe, m_pend};
    endfunction

    function automatic logic [7:0] got_vec();
        return {cnt, pwm, period_end, upd_pending};
    endfunction

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; center_mode = 1'b0; upd_req = 1'b0;
        period_in = '0; duty_in = '0;
        m_reset();
        #12 rst = 1'b0;
        total++;
        if (got_vec() !== 8'h00) begin
            bad++; $display("FAIL reset_state: got %b want %b", got_vec(), 8'h00);
        end
        period_in = 4'd15; duty_in = 8'hFF; upd_req = 1'b1;
        step(); upd_req = 1'b0;
        step(); en = 1'b1;
        for (int k = 0; k < 30; k++) begin
            upd_req = (k == 2);
            step();
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL reset_pre k%0d: got %b want %b", k, got_vec(), exp_vec());
            end
            if (cnt == 4'd6) break;
        end
        upd_req = 1'b0;
        total++;
        if ({cnt, pwm, upd_pending} !== {4'd6, 2'b11, 1'b1}) begin
            bad++; $display("FAIL reset_midrun: got %b want %b", {cnt, pwm, upd_pending}, {4'd6, 2'b11, 1'b1});
        end
        #2 rst = 1'b1;
        #1;
        m_reset();
        total++;
        if ({cnt, pwm, upd_pending, period_end} !== 8'h00) begin
            bad++; $display("FAIL reset_async: got %b want 0", {cnt, pwm, upd_pending, period_end});
        end
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < 17; k++) begin
            step();
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL reset_resume k%0d: got %b want %b", k, got_vec(), exp_vec());
            end
            if (k == 14) begin
                total++;
                if ({cnt, period_end} !== {4'd15, 1'b1}) begin
                    bad++; $display("FAIL reset_p15_end: got %b want %b", {cnt, period_end}, {4'd15, 1'b1});
                end
            end
        end
    endtask

    task automatic test_edge();
        int hi0 = 0, hi1 = 0, pe = 0, pe_cnt = -1;
        period_in = 4'd9; duty_in = {4'd0, 4'd3}; center_mode = 1'b0;
        for (int k = 0; k < 40; k++) begin
            upd_req = (k == 0);
            step();
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL edge k%0d: got %b want %b", k, got_vec(), exp_vec());
            end
            if (k >= 30) begin
                hi0 += int'(pwm[0]); hi1 += int'(pwm[1]);
                if (period_end) begin pe++; pe_cnt = int'(cnt); end
            end
        end
        upd_req = 1'b0;
        total++;
        if (hi0 != 3 || hi1 != 0 || pe != 1 || pe_cnt != 9) begin
            bad++; $display("FAIL edge_window: got hi0=%0d hi1=%0d pe=%0d at %0d want 3 0 1 at 9", hi0, hi1, pe, pe_cnt);
        end
    endtask

    task automatic test_duty_extremes();
        int hi0 = 0, hi1 = 0, lo0 = 0;
        period_in = 4'd9; duty_in = {4'd15, 4'd10};
        for (int k = 0; k < 40; k++) begin
            upd_req = (k == 0);
            step();
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL extremes_hi k%0d: got %b want %b", k, got_vec(), exp_vec());
            end
            if (k >= 30) begin hi0 += int'(pwm[0]); hi1 += int'(pwm[1]); end
        end
        total++;
        if (hi0 != 10 || hi1 != 10) begin
            bad++; $display("FAIL extremes_const_high: got %0d/%0d want 10/10", hi0, hi1);
        end
        duty_in = {4'd0, 4'd9};
        for (int k = 0; k < 40; k++) begin
            upd_req = (k == 0);
            step();
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL extremes_d9 k%0d: got %b want %b", k, got_vec(), exp_vec());
            end
            if (k >= 30) lo0 += int'(!pwm[0]);
        end
        upd_req = 1'b0;
        total++;
        if (lo0 != 1) begin
            bad++; $display("FAIL extremes_duty9_low: got %0d want 1", lo0);
        end
    endtask

    task automatic test_mid_update();
        int n = 0, hi0 = 0, pe = 0;
        bit hit = 0;
        period_in = 4'd9; duty_in = {4'd0, 4'd3};
        for (int k = 0; k < 25; k++) begin
            upd_req = (k == 0);
            step();
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL mid_setup k%0d: got %b want %b", k, got_vec(), exp_vec());
            end
        end
        upd_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (cnt == 4'd4) begin hit = 1; break; end
            step();
        end
        total++;
        if (!hit) begin
            bad++; $display("FAIL mid_wait_cnt4: got cnt=%0d want 4 (timeout)", cnt);
        end
        period_in = 4'd5; duty_in = {4'd0, 4'd2}; upd_req = 1'b1;
        step(); upd_req = 1'b0;
        while (cnt != 4'd0 && n < 20) begin
            total++;
            if (got_vec() !== exp_vec() || upd_pending !== 1'b1) begin
                bad++; $display("FAIL mid_old_wave n%0d: got %b want %b", n, got_vec(), exp_vec());
            end
            step(); n++;
        end
        total++;
        if (n != 5 || upd_pending !== 1'b0) begin
            bad++; $display("FAIL mid_apply: got steps=%0d pend=%b want 5 0", n, upd_pending);
        end
        for (int k = 0; k < 12; k++) begin
            step();
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL mid_new k%0d: got %b want %b", k, got_vec(), exp_vec());
            end
            hi0 += int'(pwm[0]); pe += int'(period_end);
        end
        total++;
        if (hi0 != 4 || pe != 2) begin
            bad++; $display("FAIL mid_new_wave: got hi=%0d pe=%0d want 4 2", hi0, pe);
        end
    endtask

    task automatic test_center();
        int seq[8] = '{0, 1, 2, 3, 4, 3, 2, 1};
        int hi0 = 0, pe = 0;
        bit hit = 0;
        period_in = 4'd4; duty_in = {4'd2, 4'd2}; center_mode = 1'b1; upd_req = 1'b1;
        step(); upd_req = 1'b0; center_mode = 1'b0;
        for (int k = 0; k < 20; k++) begin
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL center_wait k%0d: got %b want %b", k, got_vec(), exp_vec());
            end
            if (!upd_pending && cnt == 4'd0) begin hit = 1; break; end
            step();
        end
        total++;
        if (!hit) begin
            bad++; $display("FAIL center_apply: got pend=%b cnt=%0d want 0 0 (timeout)", upd_pending, cnt);
        end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (int'(cnt) != seq[k]) begin
                bad++; $display("FAIL center_seq k%0d: got %0d want %0d", k, cnt, seq[k]);
            end
            pe += int'(period_end);
            step();
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL center k%0d: got %b want %b", k, got_vec(), exp_vec());
            end
            hi0 += int'(pwm[0]);
        end
        total++;
        if (hi0 != 3 || pe != 1) begin
            bad++; $display("FAIL center_wave: got hi=%0d pe=%0d want 3 1", hi0, pe);
        end
    endtask

    task automatic test_overwrite_idle();
        int hi0 = 0;
        period_in = 4'd9; center_mode = 1'b0; duty_in = {4'd0, 4'd5}; upd_req = 1'b1;
        step();
        duty_in = {4'd0, 4'd7};
        step(); upd_req = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL overwrite k%0d: got %b want %b", k, got_vec(), exp_vec());
            end
            if (k >= 30) hi0 += int'(pwm[0]);
        end
        total++;
        if (hi0 != 7) begin
            bad++; $display("FAIL overwrite_last_wins: got %0d want 7", hi0);
        end
        duty_in = {4'd0, 4'd2}; upd_req = 1'b1;
        step(); upd_req = 1'b0; en = 1'b0;
        step();
        total++;
        if ({pwm, upd_pending, cnt, period_end} !== 8'h00 || got_vec() !== exp_vec()) begin
            bad++; $display("FAIL idle_apply: got %b want %b", got_vec(), exp_vec());
        end
        upd_req = 1'b1;
        step();
        step();
        total++;
        if (upd_pending !== 1'b1 || got_vec() !== exp_vec()) begin
            bad++; $display("FAIL upd_on_apply: got %b want %b", got_vec(), exp_vec());
        end
        upd_req = 1'b0;
        step();
        total++;
        if (upd_pending !== 1'b0 || got_vec() !== exp_vec()) begin
            bad++; $display("FAIL idle_second_apply: got %b want %b", got_vec(), exp_vec());
        end
        en = 1'b1;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            en          = ($urandom_range(0, 9) != 0);
            upd_req     = ($urandom_range(0, 11) == 0);
            period_in   = W'($urandom_range(0, 15));
            duty_in     = (N*W)'($urandom);
            center_mode = 1'($urandom_range(0, 1));
            step();
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL random k%0d: got %b want %b", k, got_vec(), exp_vec());
            end
        end
        upd_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_edge();
        test_duty_extremes();
        test_mid_update();
        test_center();
        test_overwrite_idle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_bank.md
# pwm_bank

Multi-channel, parametrised PWM generator driving the motor and brush drivers of the cleaner. A single shared period counter feeds NUM_CH independent duty comparators. Period and duties are double-buffered: new values are staged and applied only at a period boundary, so outputs never glitch. The block supports edge-aligned and center-aligned counting and flags each period end for the control loop.

## Interface
- WIDTH, 10, counter / period / duty width in bits
- NUM_CH, 4, number of PWM channels

- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous, active-high
- en  in  1  run enable; 0 holds the counter idle
- center_mode  in  1  0 = edge-aligned, 1 = center-aligned (up/down)
- period_in  in  WIDTH  staged period value P
- duty_in  in  NUM_CH*WIDTH  staged duties; channel i = bits [i*WIDTH +: WIDTH]
- upd_req  in  1  single-cycle request to capture period_in/duty_in into shadow
- pwm  out  NUM_CH  registered PWM outputs
- cnt  out  WIDTH  current counter value
- period_end  out  1  high in cycles where the counter's next value is 0
- upd_pending  out  1  shadow holds values not yet applied

## Operation
- Register sets: shadow (period, duties) and active (period_act, duty_act[i]). Compares use active values only.
- Reset values:
  - cnt=0, dir=up, pwm=0, period_end=0, upd_pending=0.
  - period_act = all ones, duty_act = 0.
  - shadow period = all ones, shadow duties = 0.
- upd_req=1: shadow <= inputs and upd_pending <= 1. A later upd_req before apply overwrites the shadow; last request wins.
- Apply: on the clock edge that loads cnt=0 while upd_pending=1, active <= shadow and upd_pending <= 0.
  - If upd_req coincides with that edge, the new inputs go to shadow, are not applied, and upd_pending stays 1.
- Edge mode:
  - cnt counts 0..P, then wraps to 0.
  - Period length is P+1 cycles.
  - P=0: cnt stays 0 and every cycle is a boundary.
- Center mode:
  - cnt counts up 0..P, then down P-1..1, then returns to 0.
  - Direction flips when cnt==P while counting up.
  - Period length is 2P cycles; P=0 behaves as in edge mode.
- Switching center_mode takes effect at the next boundary only; a mode shadow bit is latched with the other shadow values.
- Compare: pwm[i] <= en & (cnt < duty_act[i]), unsigned.
  - duty 0 gives constant low.
  - duty > P gives constant high.
- en=0:
  - cnt held at 0, dir=up, pwm <= 0, period_end=0.
  - Every idle cycle counts as a boundary, so a pending update is applied on the next edge.
- Arithmetic is WIDTH-bit unsigned with no overflow. With P = all ones, edge mode wraps naturally.

## Timing
- pwm lags cnt by one cycle (registered compare).
- period_end is combinational from cnt/dir/P/en.
- Update latency: capture occurs on the edge where upd_req=1. The new values are visible in the first cnt=0 cycle of the next period, and in pwm one cycle after that.
- Async rst forces all outputs to reset values immediately, mid-period included. The first count starts on the first edge after deassertion with en=1.

## Structure
- Package pwm_pkg: dir_t enum {DIR_UP, DIR_DOWN} and a per-channel duty slice helper.
- Sub-module pwm_channel (one per channel, via generate): holds shadow duty, active duty and the registered compare output.
  - Inputs: cnt, upd strobe, apply strobe, en.
- pwm_bank keeps the counter, direction, period/mode registers and the pending flag.

## Test plan
(Bench: WIDTH=4, NUM_CH=2.)
- Reset: assert rst mid-period at cnt=6 -> pwm=0, cnt=0, upd_pending=0 without a clock edge. Release, en=1 -> counting resumes from 0 with period_act=15.
- Edge mode: P=9, duties 3/0 -> ch0 high 3 of every 10 cycles, ch1 always low, period_end every 10th cycle at cnt=9.
- Duty extremes: P=9, duties 10/15 -> both constant high. Duty 9 -> low exactly 1 cycle per period.
- Mid-period update: running P=9, upd_req at cnt=4 with P=5, duty 2 -> old waveform continues through cnt=9, upd_pending high until the wrap, then 6-cycle periods with 2 high cycles.
- Center mode: P=4, duty 2 -> cnt sequence 0,1,2,3,4,3,2,1, pwm high for 3 of 8 cycles (cnt 0,1,1), period_end every 8 cycles.
- Overwrite and idle:
  - Two upd_req back-to-back with duties 5 then 7 -> 7 applied.
  - en=0 with a pending update -> pwm=0, update applied next edge.
  - upd_req on the apply edge -> upd_pending stays 1.
